// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the March-style RAM built-in self test.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_UP  = 3'd1,
    RW_UP = 3'd2,
    RW_DN = 3'd3,
    R_UP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] DEF_PATTERN = 32'hAAAAAAAA;

endpackage

// File: rtl/ram_bist_if.sv
// Single-port RAM bus between the BIST engine (master) and the RAM (slave).
interface ram_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (output ram_addr, output ram_data, output ram_we, input ram_q);
  modport slave  (input ram_addr, input ram_data, input ram_we, output ram_q);
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with load, enable and direction-aware terminal count.
module ram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  tc
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (en) begin
      addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
  end

  // The FSM never enables the counter while tc is high, so it cannot wrap.
  assign tc = up ? (addr == ADDR_MAX) : (addr == '0);

endmodule

// File: rtl/ram_bist.sv
// March-style RAM BIST: W_UP(P), RW_UP(rP,w~P), RW_DN(r~P,wP), R_UP(rP) on an external RAM.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(DEF_PATTERN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  ram_bist_if.master            ram,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [15:0]           err_count
);

  state_t                state, state_nxt;
  logic                  phase, phase_nxt;
  logic                  start_acc;
  logic                  cmp_en;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [DATA_WIDTH-1:0] data_c, data_hold;
  logic                  we_c;

  logic                  ag_load, ag_en, ag_up, ag_tc;
  logic [ADDR_WIDTH-1:0] ag_load_val, ag_addr;

  assign ag_up = (state != RW_DN);

  ram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .en       (ag_en),
    .up       (ag_up),
    .addr     (ag_addr),
    .tc       (ag_tc)
  );

  always_comb begin
    state_nxt   = state;
    phase_nxt   = 1'b0;
    start_acc   = 1'b0;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_en       = 1'b0;
    cmp_en      = 1'b0;
    we_c        = 1'b0;
    exp_word    = PATTERN;
    case (state)
      IDLE, DONE: begin
        if (start && !busy) begin
          start_acc = 1'b1;
          state_nxt = W_UP;
          ag_load   = 1'b1;
        end
      end
      W_UP: begin
        we_c = 1'b1;
        if (ag_tc) begin
          state_nxt = RW_UP;
          ag_load   = 1'b1;
        end else begin
          ag_en = 1'b1;
        end
      end
      RW_UP: begin
        exp_word = PATTERN;
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          we_c   = 1'b1;
          cmp_en = 1'b1;
          if (ag_tc) begin
            state_nxt   = RW_DN;
            ag_load     = 1'b1;
            ag_load_val = '1;
          end else begin
            ag_en = 1'b1;
          end
        end
      end
      RW_DN: begin
        exp_word = ~PATTERN;
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          we_c   = 1'b1;
          cmp_en = 1'b1;
          if (ag_tc) begin
            state_nxt = R_UP;
            ag_load   = 1'b1;
          end else begin
            ag_en = 1'b1;
          end
        end
      end
      R_UP: begin
        exp_word = PATTERN;
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          cmp_en = 1'b1;
          if (ag_tc) begin
            state_nxt = DONE;
          end else begin
            ag_en = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_c = data_hold;
    case (state)
      W_UP:    data_c = PATTERN;
      RW_UP:   data_c = ~PATTERN;
      RW_DN:   data_c = PATTERN;
      default: data_c = data_hold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      data_hold <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      data_hold <= data_c;
      if (start_acc) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (state == DONE && busy) begin
        // done trails entry to DONE by one edge, after the final compare has landed
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (cmp_en && (ram.ram_q !== exp_word)) begin
        if (err_count == '0) begin
          fail_addr <= ag_addr;
          fail_data <= ram.ram_q;
        end
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

  assign ram.ram_addr = ag_addr;
  assign ram.ram_data = data_c;
  assign ram.ram_we   = we_c;
  assign pass         = done && (err_count == '0);

endmodule
